stage_if_mt: RTL

- Parametrised multithreaded instruction-fetch controller, successor to the fixed 2-stage fetch stage.
- Each cycle it picks one eligible thread with a stall-aware round-robin, drives an external I-TLB/I-cache lookup and registers the result into the IF/ID latch.
- The IF/ID latch carries a valid/ready handshake.
- Per-thread miss tracking: threads that miss sleep until their line returns. Misses to the same line are merged, and only one memory request is outstanding at a time.

---
 rtl/stage_if_mt.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/stage_if_mt.sv
// Multithreaded instruction-fetch controller: round-robin thread pick, external
// I-TLB/I-cache lookup, IF/ID latch, per-thread miss sleep with merged line fills.
module stage_if_mt #(
   parameter int N_THREADS  = 4,
   parameter int VADDR_W    = 32,
   parameter int PADDR_W    = 32,
   parameter int WORD_W     = 32,
   parameter int LINE_BYTES = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_THREADS*VADDR_W-1:0]   pc_flat,
   input  logic [N_THREADS-1:0]           thread_en,
   output logic                           lkp_valid,
   output logic [$clog2(N_THREADS)-1:0]   lkp_thread,
   output logic [VADDR_W-1:0]             lkp_vaddr,
   input  logic                           lkp_itlb_miss,
   input  logic                           lkp_icache_miss,
   input  logic [PADDR_W-1:0]             lkp_paddr,
   input  logic [WORD_W-1:0]              lkp_data,
   output logic                           id_valid,
   input  logic                           id_ready,
   output logic [VADDR_W-1:0]             id_pc,
   output logic [WORD_W-1:0]              id_instruction,
   output logic [$clog2(N_THREADS)-1:0]   id_thread,
   output logic                           id_itlb_miss,
   output logic                           mem_req_valid,
   output logic [PADDR_W-1:0]             mem_req_addr,
   input  logic                           mem_req_ready,
   input  logic                           mem_rec_en,
   input  logic [PADDR_W-1:0]             mem_rec_addr,
   output logic [N_THREADS-1:0]           waiting
);

   localparam int TW    = $clog2(N_THREADS);
   localparam int LOFF  = $clog2(LINE_BYTES);
   localparam int TAG_W = PADDR_W - LOFF;

   logic [N_THREADS-1:0] waiting_q, waiting_d;
   logic [TW-1:0]        rr_last_q, rr_last_d;
   logic                 id_valid_q, id_valid_d;
   logic [VADDR_W-1:0]   id_pc_q, id_pc_d;
   logic [WORD_W-1:0]    id_instruction_q, id_instruction_d;
   logic [TW-1:0]        id_thread_q, id_thread_d;
   logic                 id_itlb_miss_q, id_itlb_miss_d;
   logic [TAG_W-1:0]     tag_q [N_THREADS];
   logic [TAG_W-1:0]     tag_d [N_THREADS];
   logic [TAG_W-1:0]     fifo_q [N_THREADS];
   logic [TAG_W-1:0]     fifo_d [N_THREADS];
   logic [N_THREADS-1:0] fifo_vld_q, fifo_vld_d;
   logic [TW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [TW-1:0]        rd_ptr_q, rd_ptr_d;
   logic                 outstanding_q, outstanding_d;
   logic [TAG_W-1:0]     out_tag_q, out_tag_d;

   logic [N_THREADS-1:0] elig;
   logic                 advance;
   logic                 lkp_fire;
   logic                 sel_found;
   logic [TW-1:0]        sel;
   logic [VADDR_W-1:0]   pc_arr [N_THREADS];
   logic [TAG_W-1:0]     lkp_tag;
   logic [TAG_W-1:0]     rec_tag;
   logic                 refill_hit;
   logic                 req_fire;
   logic                 tag_pending;

   function automatic logic [TW-1:0] ptr_inc(input logic [TW-1:0] p);
      return (p == TW'(N_THREADS - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      for (int t = 0; t < N_THREADS; t++) begin
         pc_arr[t] = pc_flat[t*VADDR_W +: VADDR_W];
      end
   end

   // First eligible thread after rr_last, wrapping modulo N_THREADS.
   always_comb begin : sel_blk
      int          idx;
      logic [TW-1:0] cand;
      sel       = '0;
      sel_found = 1'b0;
      idx       = 0;
      cand      = '0;
      for (int i = 1; i <= N_THREADS; i++) begin
         idx = int'(rr_last_q) + i;
         if (idx >= N_THREADS) idx = idx - N_THREADS;
         cand = TW'(idx);
         if (!sel_found && elig[cand]) begin
            sel_found = 1'b1;
            sel       = cand;
         end
      end
   end

   always_comb begin
      elig          = thread_en & ~waiting_q;
      advance       = !id_valid_q || id_ready;
      lkp_fire      = !rst && advance && sel_found;
      lkp_tag       = TAG_W'(lkp_paddr >> LOFF);
      rec_tag       = TAG_W'(mem_rec_addr >> LOFF);
      refill_hit    = mem_rec_en && outstanding_q && (rec_tag == out_tag_q);
      mem_req_valid = !outstanding_q && (|fifo_vld_q);
      req_fire      = mem_req_valid && mem_req_ready;
      tag_pending   = outstanding_q && (out_tag_q == lkp_tag);
      for (int i = 0; i < N_THREADS; i++) begin
         if (fifo_vld_q[i] && (fifo_q[i] == lkp_tag)) tag_pending = 1'b1;
      end
   end

   always_comb begin
      waiting_d        = waiting_q;
      rr_last_d        = rr_last_q;
      id_valid_d       = id_valid_q;
      id_pc_d          = id_pc_q;
      id_instruction_d = id_instruction_q;
      id_thread_d      = id_thread_q;
      id_itlb_miss_d   = id_itlb_miss_q;
      tag_d            = tag_q;
      fifo_d           = fifo_q;
      fifo_vld_d       = fifo_vld_q;
      wr_ptr_d         = wr_ptr_q;
      rd_ptr_d         = rd_ptr_q;
      outstanding_d    = outstanding_q;
      out_tag_d        = out_tag_q;

      if (lkp_fire) rr_last_d = sel;

      // Refill wakes every sleeper on the returned line at once.
      if (refill_hit) begin
         outstanding_d = 1'b0;
         for (int t = 0; t < N_THREADS; t++) begin
            if (waiting_q[t] && (tag_q[t] == out_tag_q)) waiting_d[t] = 1'b0;
         end
      end

      if (req_fire) begin
         fifo_vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d             = ptr_inc(rd_ptr_q);
         outstanding_d        = 1'b1;
         out_tag_d            = fifo_q[rd_ptr_q];
      end

      if (advance) begin
         id_valid_d = 1'b0;
         if (lkp_fire) begin
            if (lkp_itlb_miss) begin
               id_valid_d       = 1'b1;
               id_pc_d          = pc_arr[sel];
               id_instruction_d = '0;
               id_thread_d      = sel;
               id_itlb_miss_d   = 1'b1;
            end else if (!lkp_icache_miss) begin
               id_valid_d       = 1'b1;
               id_pc_d          = pc_arr[sel];
               id_instruction_d = lkp_data;
               id_thread_d      = sel;
               id_itlb_miss_d   = 1'b0;
            end else begin
               tag_d[sel] = lkp_tag;
               // A line landing this very cycle lets the thread just retry.
               if (!(mem_rec_en && (rec_tag == lkp_tag))) begin
                  waiting_d[sel] = 1'b1;
                  if (!tag_pending) begin
                     fifo_vld_d[wr_ptr_q] = 1'b1;
                     fifo_d[wr_ptr_q]     = lkp_tag;
                     wr_ptr_d             = ptr_inc(wr_ptr_q);
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         waiting_q        <= '0;
         rr_last_q        <= TW'(N_THREADS - 1);
         id_valid_q       <= 1'b0;
         id_pc_q          <= '0;
         id_instruction_q <= '0;
         id_thread_q      <= '0;
         id_itlb_miss_q   <= 1'b0;
         fifo_vld_q       <= '0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         outstanding_q    <= 1'b0;
         out_tag_q        <= '0;
         for (int t = 0; t < N_THREADS; t++) begin
            tag_q[t]  <= '0;
            fifo_q[t] <= '0;
         end
      end else begin
         waiting_q        <= waiting_d;
         rr_last_q        <= rr_last_d;
         id_valid_q       <= id_valid_d;
         id_pc_q          <= id_pc_d;
         id_instruction_q <= id_instruction_d;
         id_thread_q      <= id_thread_d;
         id_itlb_miss_q   <= id_itlb_miss_d;
         fifo_vld_q       <= fifo_vld_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         outstanding_q    <= outstanding_d;
         out_tag_q        <= out_tag_d;
         for (int t = 0; t < N_THREADS; t++) begin
            tag_q[t]  <= tag_d[t];
            fifo_q[t] <= fifo_d[t];
         end
      end
   end

   assign lkp_valid      = lkp_fire;
   assign lkp_thread     = lkp_fire ? sel : '0;
   assign lkp_vaddr      = lkp_fire ? pc_arr[sel] : '0;
   assign id_valid       = id_valid_q;
   assign id_pc          = id_pc_q;
   assign id_instruction = id_instruction_q;
   assign id_thread      = id_thread_q;
   assign id_itlb_miss   = id_itlb_miss_q;
   assign mem_req_addr   = mem_req_valid ? {fifo_q[rd_ptr_q], {LOFF{1'b0}}} : '0;
   assign waiting        = waiting_q;

endmodule
